// File: rtl/draw_pkg.sv
// Shared definitions for the board renderer and the board logic that
// addresses the same RAM: geometry defaults, the empty-cell colour, the
// scan FSM encoding and the cell address mapping.
package draw_pkg;

    localparam int DEF_COLOUR_W    = 6;
    localparam int DEF_BOARD_W     = 10;
    localparam int DEF_BOARD_H     = 24;
    localparam int DEF_HIDDEN_ROWS = 4;

    // Colour value stored in a cell that holds no block.
    localparam int EMPTY_COLOUR    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Row-major board RAM layout: one word per cell.
    function automatic int unsigned cell_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned board_w);
        return row * board_w + col;
    endfunction

endpackage

// File: rtl/cell_pixel_counter.sv
// Pixel offset generator for one square cell of 2**CELL_LOG2 pixels per
// edge. ox runs fastest, oy steps when ox wraps. o_last flags the final
// pixel of the cell so the scanner knows when to move on.
module cell_pixel_counter #(
    parameter int CELL_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_en,
    output logic [CELL_LOG2-1:0] o_ox,
    output logic [CELL_LOG2-1:0] o_oy,
    output logic                 o_last
);

    // {oy, ox} kept as one counter so the ox wrap carries into oy for free.
    logic [2*CELL_LOG2-1:0] r_cnt;

    // Offset counter: clear wins over enable so each cell starts at (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ox   = r_cnt[CELL_LOG2-1:0];
    assign o_oy   = r_cnt[2*CELL_LOG2-1:CELL_LOG2];
    assign o_last = &r_cnt;

endmodule

// File: rtl/draw_board_scan.sv
// Board renderer: walks the visible rows of the board RAM cell by cell,
// fetches each colour and emits one VGA pixel write per clock for every
// pixel of the cell. Controlled by the game FSM through start/abort and
// reports progress with busy/done.
module draw_board_scan
    import draw_pkg::*;
#(
    parameter int BOARD_W     = DEF_BOARD_W,
    parameter int BOARD_H     = DEF_BOARD_H,
    parameter int HIDDEN_ROWS = DEF_HIDDEN_ROWS,
    parameter int CELL_LOG2   = 2,
    parameter int X_ORIGIN    = 0,
    parameter int Y_ORIGIN    = 0,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int ADDR_W      = 8,
    parameter int RAM_LATENCY = 1,
    parameter int SKIP_EMPTY  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [COLOUR_W-1:0] ram_q,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int ROW_W  = $clog2(BOARD_H + 1);
    localparam int COL_W  = $clog2(BOARD_W + 1);
    localparam int CELL   = 1 << CELL_LOG2;
    localparam int MAX_X  = X_ORIGIN + BOARD_W * CELL - 1;
    localparam int MAX_Y  = Y_ORIGIN + (BOARD_H - HIDDEN_ROWS) * CELL - 1;

    // Geometry that cannot be represented on the outputs is rejected at
    // elaboration rather than silently wrapping on screen.
    if (MAX_X > 255) begin : g_bad_x
        $error("draw_board_scan: rightmost pixel x exceeds 255");
    end
    if (MAX_Y > 127) begin : g_bad_y
        $error("draw_board_scan: bottom pixel y exceeds 127");
    end
    if (BOARD_W * BOARD_H > (1 << ADDR_W)) begin : g_bad_addr
        $error("draw_board_scan: board does not fit in ADDR_W address bits");
    end
    if (RAM_LATENCY < 1 || RAM_LATENCY > 2) begin : g_bad_lat
        $error("draw_board_scan: RAM_LATENCY must be 1 or 2");
    end
    if (CELL_LOG2 < 1) begin : g_bad_cell
        $error("draw_board_scan: CELL_LOG2 must be at least 1");
    end
    if (HIDDEN_ROWS >= BOARD_H) begin : g_bad_rows
        $error("draw_board_scan: no visible rows");
    end

    scan_state_t          r_state;
    scan_state_t          w_next;

    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic                 r_lat_cnt;
    logic [COLOUR_W-1:0]  r_cell_colour;

    // Last values presented on the bus, shown whenever the bus is idle.
    logic [ADDR_W-1:0]    r_addr_hold;
    logic [7:0]           r_x;
    logic [6:0]           r_y;
    logic [COLOUR_W-1:0]  r_colour;

    logic                 w_accept;
    logic                 w_advance;
    logic                 w_in_fetch;
    logic                 w_in_draw;
    logic                 w_fetch_last;
    logic                 w_skip;
    logic                 w_last_col;
    logic                 w_last_cell;
    logic                 w_pix_last;
    logic [CELL_LOG2-1:0] w_ox;
    logic [CELL_LOG2-1:0] w_oy;
    logic [ADDR_W-1:0]    w_addr;
    logic [9:0]           w_x10;
    logic [9:0]           w_y10;

    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_in_draw   = (r_state == ST_DRAW);
    assign w_last_col  = (r_col == COL_W'(BOARD_W - 1));
    assign w_last_cell = w_last_col && (r_row == ROW_W'(BOARD_H - 1));

    // With a one-cycle RAM every FETCH cycle is the sampling cycle; with a
    // two-cycle RAM the first cycle only waits for the data to arrive.
    assign w_fetch_last = (RAM_LATENCY == 1) ? 1'b1 : r_lat_cnt;

    // An empty cell is only elided when skipping is enabled.
    assign w_skip = (SKIP_EMPTY != 0) && (ram_q == COLOUR_W'(EMPTY_COLOUR));

    assign w_addr = ADDR_W'(cell_addr(32'(r_row), 32'(r_col), BOARD_W));

    // Screen position at full 10-bit precision; the elaboration checks
    // above guarantee the truncation to 8/7 bits never loses information.
    assign w_x10 = 10'(X_ORIGIN) + (10'(r_col) << CELL_LOG2) + 10'(w_ox);
    assign w_y10 = 10'(Y_ORIGIN)
                 + ((10'(r_row) - 10'(HIDDEN_ROWS)) << CELL_LOG2)
                 + 10'(w_oy);

    cell_pixel_counter #(
        .CELL_LOG2 (CELL_LOG2)
    ) u_pix (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!w_in_draw),
        .i_en    (w_in_draw),
        .o_ox    (w_ox),
        .o_oy    (w_oy),
        .o_last  (w_pix_last)
    );

    // Scan state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the accept/advance strobes that steer the
    // row/column walk. Abort outranks everything while a scan is active.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next   = ST_FETCH;
                    w_accept = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_next = ST_DONE;
                end else if (w_fetch_last) begin
                    if (w_skip) begin
                        w_advance = 1'b1;
                        w_next    = w_last_cell ? ST_DONE : ST_FETCH;
                    end else begin
                        w_next = ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                if (abort) begin
                    w_next = ST_DONE;
                end else if (w_pix_last) begin
                    w_advance = 1'b1;
                    w_next    = w_last_cell ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                // Back-to-back scans: a start seen here skips IDLE.
                if (start) begin
                    w_next   = ST_FETCH;
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Row/column walk over the visible part of the board, row-major.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_row <= ROW_W'(HIDDEN_ROWS);
            r_col <= '0;
        end else if (w_advance && !w_last_cell) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // RAM wait counter: marks the second FETCH cycle of a two-cycle read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lat_cnt <= 1'b0;
        end else begin
            r_lat_cnt <= w_in_fetch && !w_fetch_last && !abort;
        end
    end

    // Capture the cell colour on the cycle the RAM data is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cell_colour <= '0;
        end else if (w_in_fetch && w_fetch_last) begin
            r_cell_colour <= ram_q;
        end
    end

    // Remember the last address and pixel so the outputs hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_hold <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_colour    <= '0;
        end else begin
            if (w_in_fetch) begin
                r_addr_hold <= w_addr;
            end
            if (w_in_draw) begin
                r_x      <= 8'(w_x10);
                r_y      <= 7'(w_y10);
                r_colour <= r_cell_colour;
            end
        end
    end

    // Live values while active, held values otherwise; all of these fall
    // to zero the moment reset asserts because they hinge on r_state.
    assign ram_addr = w_in_fetch ? w_addr        : r_addr_hold;
    assign x        = w_in_draw  ? 8'(w_x10)     : r_x;
    assign y        = w_in_draw  ? 7'(w_y10)     : r_y;
    assign colour   = w_in_draw  ? r_cell_colour : r_colour;
    assign plot     = w_in_draw;
    assign busy     = w_in_fetch || w_in_draw;
    assign done     = (r_state == ST_DONE);

endmodule
